// File: rtl/bicubic_weight_gen.sv
// Four-stage pipelined generator of the four Keys bicubic (or bilinear) tap weights
// for one fractional position per sample. The weights are renormalised so they sum to ONE.
module bicubic_weight_gen #(
  parameter int FRAC_W   = 8,
  parameter int A_W      = 10,
  parameter int A_FRAC   = 8,
  parameter int W_FRAC   = 10,
  parameter int WEIGHT_W = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FRAC_W-1:0]          t_frac,
  input  logic signed [A_W-1:0]      coeff_a,
  input  logic                       mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [WEIGHT_W-1:0] w0,
  output logic signed [WEIGHT_W-1:0] w1,
  output logic signed [WEIGHT_W-1:0] w2,
  output logic signed [WEIGHT_W-1:0] w3,
  output logic                       out_sat
);

  localparam int DW = FRAC_W + 2;
  localparam int SW = 2 * DW;
  localparam int CW = 3 * DW;
  localparam int KW = A_W + 4;
  localparam int P  = 3 * FRAC_W + A_FRAC;
  localparam int PW = CW + KW + 4;
  localparam int SH = P - W_FRAC;

  localparam logic [DW-1:0]          ONE_D   = DW'(1 << FRAC_W);
  localparam logic [DW-1:0]          TWO_D   = DW'(2 << FRAC_W);
  localparam logic signed [KW-1:0]   TWO_A   = KW'(2 << A_FRAC);
  localparam logic signed [KW-1:0]   THREE_A = KW'(3 << A_FRAC);
  localparam logic signed [PW-1:0]   ONEP    = PW'(1) << P;
  localparam logic signed [PW-1:0]   HALF    = PW'(1) << (SH - 1);
  localparam logic signed [PW-1:0]   ONEW    = PW'(1) << W_FRAC;
  localparam logic signed [PW-1:0]   MAXW    = PW'((1 << (WEIGHT_W - 1)) - 1);
  localparam logic signed [PW-1:0]   MINW    = -MAXW;

  logic advance;

  logic                     v1, m1;
  logic [FRAC_W-1:0]        t1;
  logic signed [A_W-1:0]    a1;
  logic [DW-1:0]            dS1 [4];

  logic                     v2, m2;
  logic [FRAC_W-1:0]        t2;
  logic [DW-1:0]            dS2 [4];
  logic [SW-1:0]            sqS2 [4];
  logic signed [KW-1:0]     aS2, ap2S2, ap3S2, a5S2, a8S2, a4S2;
  logic signed [KW-1:0]     aExt;

  logic                     v3, m3;
  logic [FRAC_W-1:0]        t3;
  logic signed [PW-1:0]     pS3 [4];
  logic signed [PW-1:0]     pNext [4];

  logic signed [PW-1:0]       rnd [4];
  logic signed [WEIGHT_W-1:0] rW [4];
  logic signed [WEIGHT_W-1:0] nW [4];
  logic [3:0]                 rSat;
  logic [1:0]                 corrIdx;
  logic signed [PW-1:0]       sumOthers, corrFull;
  logic signed [WEIGHT_W-1:0] tW;
  logic                       satNext;

  function automatic logic signed [PW-1:0] sext(input logic signed [KW-1:0] v);
    return {{(PW-KW){v[KW-1]}}, v};
  endfunction

  function automatic logic signed [PW-1:0] sextW(input logic signed [WEIGHT_W-1:0] v);
    return {{(PW-WEIGHT_W){v[WEIGHT_W-1]}}, v};
  endfunction

  function automatic logic signed [WEIGHT_W-1:0] clampW(input logic signed [PW-1:0] v);
    if (v > MAXW) return MAXW[WEIGHT_W-1:0];
    if (v < MINW) return MINW[WEIGHT_W-1:0];
    return v[WEIGHT_W-1:0];
  endfunction

  // Every term is aligned to Q.P (3*FRAC_W + A_FRAC fractional bits) so nothing is lost before rounding
  function automatic logic signed [PW-1:0] tapPoly(
    input logic [DW-1:0] d, input logic [SW-1:0] sq, input logic inner,
    input logic signed [KW-1:0] a, input logic signed [KW-1:0] ap2, input logic signed [KW-1:0] ap3,
    input logic signed [KW-1:0] a5, input logic signed [KW-1:0] a8, input logic signed [KW-1:0] a4);
    logic signed [PW-1:0] x1, x2, x3;
    x1 = {{(PW-DW){1'b0}}, d};
    x2 = {{(PW-SW){1'b0}}, sq};
    x3 = x2 * x1;
    if (inner) return sext(ap2) * x3 - ((sext(ap3) * x2) <<< FRAC_W) + ONEP;
    return sext(a) * x3 - ((sext(a5) * x2) <<< FRAC_W)
           + ((sext(a8) * x1) <<< (2 * FRAC_W)) - (sext(a4) <<< (3 * FRAC_W));
  endfunction

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      m1 <= 1'b0;
      t1 <= '0;
      a1 <= '0;
      for (int k = 0; k < 4; k++) dS1[k] <= '0;
    end else if (advance) begin
      v1     <= in_valid;
      m1     <= mode;
      t1     <= t_frac;
      a1     <= coeff_a;
      dS1[0] <= ONE_D + DW'(t_frac);
      dS1[1] <= DW'(t_frac);
      dS1[2] <= ONE_D - DW'(t_frac);
      dS1[3] <= TWO_D - DW'(t_frac);
    end
  end

  assign aExt = {{(KW-A_W){a1[A_W-1]}}, a1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2    <= 1'b0;
      m2    <= 1'b0;
      t2    <= '0;
      aS2   <= '0;
      ap2S2 <= '0;
      ap3S2 <= '0;
      a5S2  <= '0;
      a8S2  <= '0;
      a4S2  <= '0;
      for (int k = 0; k < 4; k++) begin
        dS2[k]  <= '0;
        sqS2[k] <= '0;
      end
    end else if (advance) begin
      v2    <= v1;
      m2    <= m1;
      t2    <= t1;
      aS2   <= aExt;
      ap2S2 <= aExt + TWO_A;
      ap3S2 <= aExt + THREE_A;
      a5S2  <= (aExt <<< 2) + aExt;
      a8S2  <= aExt <<< 3;
      a4S2  <= aExt <<< 2;
      for (int k = 0; k < 4; k++) begin
        dS2[k]  <= dS1[k];
        sqS2[k] <= SW'(dS1[k]) * SW'(dS1[k]);
      end
    end
  end

  // d0 sits exactly on |x|=1 at t=0, where only the inner kernel is defined
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      pNext[k] = tapPoly(dS2[k], sqS2[k], (k == 1) || (k == 2) || ((k == 0) && (t2 == '0)),
                         aS2, ap2S2, ap3S2, a5S2, a8S2, a4S2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3 <= 1'b0;
      m3 <= 1'b0;
      t3 <= '0;
      for (int k = 0; k < 4; k++) pS3[k] <= '0;
    end else if (advance) begin
      v3 <= v2;
      m3 <= m2;
      t3 <= t2;
      for (int k = 0; k < 4; k++) pS3[k] <= pNext[k];
    end
  end

  // The tap nearest the sample point absorbs the rounding residue
  always_comb begin
    sumOthers = '0;
    for (int k = 0; k < 4; k++) begin
      rnd[k]  = (pS3[k] + HALF) >>> SH;
      rW[k]   = clampW(rnd[k]);
      rSat[k] = (rnd[k] > MAXW) || (rnd[k] < MINW);
      nW[k]   = rW[k];
    end
    corrIdx = t3[FRAC_W-1] ? 2'd2 : 2'd1;
    for (int k = 0; k < 4; k++) begin
      if (k != int'(corrIdx)) sumOthers = sumOthers + sextW(rW[k]);
    end
    corrFull    = ONEW - sumOthers;
    nW[corrIdx] = clampW(corrFull);
    satNext     = (|rSat) || (corrFull > MAXW) || (corrFull < MINW);
    tW          = {{(WEIGHT_W-FRAC_W){1'b0}}, t3} << (W_FRAC - FRAC_W);
    if (m3) begin
      nW[0]   = '0;
      nW[1]   = ONEW[WEIGHT_W-1:0] - tW;
      nW[2]   = tW;
      nW[3]   = '0;
      satNext = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      w0        <= '0;
      w1        <= '0;
      w2        <= '0;
      w3        <= '0;
      out_sat   <= 1'b0;
    end else if (advance) begin
      out_valid <= v3;
      if (v3) begin
        w0      <= nW[0];
        w1      <= nW[1];
        w2      <= nW[2];
        w3      <= nW[3];
        out_sat <= satNext;
      end
    end
  end

endmodule
